// File: rtl/draw_card_grid_if.sv
// VGA bus as seen by the card-grid overlay: sync, blanking, position and colour.
// Driver-side and receiver-side modports.
interface draw_card_grid_if;
    logic        hs;
    logic        vs;
    logic        hblnk;
    logic        vblnk;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic [11:0] rgb;

    modport master (output hs, vs, hblnk, vblnk, hcount, vcount, rgb);
    modport slave  (input  hs, vs, hblnk, vblnk, hcount, vcount, rgb);
endinterface

// File: rtl/draw_card_grid.sv
// Overlays the 4x4 memory-card grid on the VGA stream with a 2-cycle pipeline.
// The card table is double-buffered and committed at every vblank rising edge.
module draw_card_grid #(
    parameter int          GRID_X     = 384,
    parameter int          GRID_Y     = 272,
    parameter int          PITCH_LOG2 = 6,
    parameter int          CARD_SIZE  = 56,
    parameter int          BORDER     = 4,
    parameter int          BLINK_LOG2 = 5,
    parameter logic [11:0] BACK_COLOR = 12'h35a
) (
    input  logic             pclk,
    input  logic             rst_n,
    draw_card_grid_if.slave  vga_in,
    draw_card_grid_if.master vga_out,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [1:0]       wr_state,
    input  logic [2:0]       wr_symbol,
    input  logic [3:0]       cursor_idx,
    input  logic             cursor_en,
    output logic             frame_tick
);

    localparam int P = PITCH_LOG2;
    localparam logic [10:0]  GX    = 11'(GRID_X);
    localparam logic [10:0]  GY    = 11'(GRID_Y);
    localparam logic [10:0]  SPAN  = 11'(4 << PITCH_LOG2);
    localparam logic [P-1:0] CS    = P'(CARD_SIZE);
    localparam logic [P-1:0] BW    = P'(BORDER);
    localparam logic [P-1:0] CS_BW = P'(CARD_SIZE - BORDER);

    localparam logic [1:0] ST_REVEALED = 2'b01;
    localparam logic [1:0] ST_MATCHED  = 2'b10;

    function automatic logic [11:0] palette(input logic [2:0] sym);
        case (sym)
            3'd0:    palette = 12'hf00;
            3'd1:    palette = 12'h0f0;
            3'd2:    palette = 12'h00f;
            3'd3:    palette = 12'hff0;
            3'd4:    palette = 12'hf0f;
            3'd5:    palette = 12'h0ff;
            3'd6:    palette = 12'hf80;
            default: palette = 12'h8f8;
        endcase
    endfunction

    // Card tables: pending is written by the game FSM, active is what gets drawn.
    logic [1:0] pend_state [16];
    logic [2:0] pend_sym   [16];
    logic [1:0] act_state  [16];
    logic [2:0] act_sym    [16];
    logic [3:0] act_cursor;
    logic       act_cursor_en;
    logic       vblnk_prev;
    logic [BLINK_LOG2-1:0] frame_cnt;
    logic       commit;

    assign commit = vga_in.vblnk && !vblnk_prev;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                pend_state[i] <= '0;
                pend_sym[i]   <= '0;
                act_state[i]  <= '0;
                act_sym[i]    <= '0;
            end
            act_cursor    <= '0;
            act_cursor_en <= 1'b0;
            vblnk_prev    <= 1'b0;
            frame_cnt     <= '0;
            frame_tick    <= 1'b0;
        end else begin
            vblnk_prev <= vga_in.vblnk;
            frame_tick <= commit;
            if (wr_en) begin
                pend_state[wr_addr] <= wr_state;
                pend_sym[wr_addr]   <= wr_symbol;
            end
            // Non-blocking copy: a write on the commit edge lands in pending only.
            if (commit) begin
                for (int i = 0; i < 16; i++) begin
                    act_state[i] <= pend_state[i];
                    act_sym[i]   <= pend_sym[i];
                end
                act_cursor    <= cursor_idx;
                act_cursor_en <= cursor_en;
                frame_cnt     <= frame_cnt + 1'b1;
            end
        end
    end

    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_grid;

    assign dx      = vga_in.hcount - GX;
    assign dy      = vga_in.vcount - GY;
    assign in_grid = (vga_in.hcount >= GX) && (dx < SPAN) &&
                     (vga_in.vcount >= GY) && (dy < SPAN);

    logic        s1_hs, s1_vs, s1_hblnk, s1_vblnk;
    logic [10:0] s1_hcount, s1_vcount;
    logic [11:0] s1_rgb;
    logic        s1_in_grid;
    logic [1:0]  s1_col, s1_row;
    logic [P-1:0] s1_offx, s1_offy;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hs      <= 1'b0;
            s1_vs      <= 1'b0;
            s1_hblnk   <= 1'b0;
            s1_vblnk   <= 1'b0;
            s1_hcount  <= '0;
            s1_vcount  <= '0;
            s1_rgb     <= '0;
            s1_in_grid <= 1'b0;
            s1_col     <= '0;
            s1_row     <= '0;
            s1_offx    <= '0;
            s1_offy    <= '0;
        end else begin
            s1_hs      <= vga_in.hs;
            s1_vs      <= vga_in.vs;
            s1_hblnk   <= vga_in.hblnk;
            s1_vblnk   <= vga_in.vblnk;
            s1_hcount  <= vga_in.hcount;
            s1_vcount  <= vga_in.vcount;
            s1_rgb     <= vga_in.rgb;
            s1_in_grid <= in_grid;
            s1_col     <= dx[P+1:P];
            s1_row     <= dy[P+1:P];
            s1_offx    <= dx[P-1:0];
            s1_offy    <= dy[P-1:0];
        end
    end

    logic [3:0]  card;
    logic        on_card;
    logic        on_edge;
    logic        border;
    logic [11:0] rgb_next;

    assign card = {s1_row, s1_col};

    always_comb begin
        on_card  = s1_in_grid && (s1_offx < CS) && (s1_offy < CS);
        on_edge  = (s1_offx < BW) || (s1_offx >= CS_BW) ||
                   (s1_offy < BW) || (s1_offy >= CS_BW);
        border   = on_card && on_edge && act_cursor_en && (card == act_cursor) &&
                   !frame_cnt[BLINK_LOG2-1];
        rgb_next = s1_rgb;
        if (s1_hblnk || s1_vblnk || !on_card) begin
            rgb_next = s1_rgb;
        end else if (border) begin
            rgb_next = 12'hfff;
        end else begin
            case (act_state[card])
                ST_REVEALED: rgb_next = palette(act_sym[card]);
                ST_MATCHED:  rgb_next = s1_rgb;
                default:     rgb_next = BACK_COLOR;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vga_out.hs     <= 1'b0;
            vga_out.vs     <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hs     <= s1_hs;
            vga_out.vs     <= s1_vs;
            vga_out.hblnk  <= s1_hblnk;
            vga_out.vblnk  <= s1_vblnk;
            vga_out.hcount <= s1_hcount;
            vga_out.vcount <= s1_vcount;
            vga_out.rgb    <= rgb_next;
        end
    end

endmodule

// File: tb/tb_draw_card_grid.sv
// Self-checking bench for draw_card_grid: directed scenarios plus randomized raster
// traffic, all compared against a pixel-level reference model of the card grid.
module tb_draw_card_grid;

    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    always #5 pclk = ~pclk;

    draw_card_grid_if vga_in ();
    draw_card_grid_if vga_out ();

    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [1:0] wr_state = '0;
    logic [2:0] wr_symbol = '0;
    logic [3:0] cursor_idx = '0;
    logic       cursor_en = 1'b0;
    logic       frame_tick;

    draw_card_grid dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .vga_in     (vga_in),
        .vga_out    (vga_out),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_state   (wr_state),
        .wr_symbol  (wr_symbol),
        .cursor_idx (cursor_idx),
        .cursor_en  (cursor_en),
        .frame_tick (frame_tick)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [37:0] got, input logic [37:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: card tables, cursor and frame counter as plain integers.
    int m_pend_st [16];
    int m_pend_sym[16];
    int m_act_st  [16];
    int m_act_sym [16];
    int m_cur, m_cur_en, m_frame;
    bit m_vprev;
    logic [37:0] exp_q1, exp_out;
    logic        exp_tick;
    logic [11:0] pal [8] = '{12'hf00, 12'h0f0, 12'h00f, 12'hff0,
                             12'hf0f, 12'h0ff, 12'hf80, 12'h8f8};

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_pend_st[i] = 0; m_pend_sym[i] = 0; m_act_st[i] = 0; m_act_sym[i] = 0;
        end
        m_cur = 0; m_cur_en = 0; m_frame = 0; m_vprev = 0;
        exp_q1 = '0; exp_out = '0; exp_tick = 1'b0;
    endtask

    function automatic logic [11:0] ref_rgb(input logic hb, input logic vb,
                                            input logic [10:0] hc, input logic [10:0] vc,
                                            input logic [11:0] rgb);
        int x, y, ox, oy, card;
        if (hb || vb) return rgb;
        if (hc < 384 || hc >= 384 + 4 * 64 || vc < 272 || vc >= 272 + 4 * 64) return rgb;
        x = int'(hc) - 384;
        y = int'(vc) - 272;
        ox = x % 64;
        oy = y % 64;
        card = (y / 64) * 4 + x / 64;
        if (ox >= 56 || oy >= 56) return rgb;
        if (m_cur_en != 0 && m_cur == card && (m_frame % 32) < 16 &&
            (ox < 4 || ox >= 52 || oy < 4 || oy >= 52)) return 12'hfff;
        case (m_act_st[card])
            1:       return pal[m_act_sym[card]];
            2:       return rgb;
            default: return 12'h35a;
        endcase
    endfunction

    function automatic logic [37:0] out_bus();
        return {vga_out.hs, vga_out.vs, vga_out.hblnk, vga_out.vblnk,
                vga_out.hcount, vga_out.vcount, vga_out.rgb};
    endfunction

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        logic commit;
        @(posedge pclk);
        if (!rst_n) begin
            m_reset();
        end else begin
            commit = vga_in.vblnk && !m_vprev;
            if (commit) begin
                for (int i = 0; i < 16; i++) begin
                    m_act_st[i] = m_pend_st[i];
                    m_act_sym[i] = m_pend_sym[i];
                end
                m_cur = int'(cursor_idx);
                m_cur_en = int'(cursor_en);
                m_frame = (m_frame + 1) % 32;
            end
            if (wr_en) begin
                m_pend_st[wr_addr] = int'(wr_state);
                m_pend_sym[wr_addr] = int'(wr_symbol);
            end
            m_vprev = vga_in.vblnk;
            exp_out = exp_q1;
            exp_q1 = {vga_in.hs, vga_in.vs, vga_in.hblnk, vga_in.vblnk, vga_in.hcount,
                      vga_in.vcount,
                      ref_rgb(vga_in.hblnk, vga_in.vblnk, vga_in.hcount, vga_in.vcount,
                              vga_in.rgb)};
            exp_tick = commit;
        end
        #1;
        check_val("vga_out", out_bus(), exp_out);
        check_val("frame_tick", 38'(frame_tick), 38'(exp_tick));
    endtask

    task automatic set_pix(input logic hb, input logic vb, input int hc, input int vc,
                           input logic [11:0] rgb);
        vga_in.hs = 1'b0;
        vga_in.vs = 1'b0;
        vga_in.hblnk = hb;
        vga_in.vblnk = vb;
        vga_in.hcount = 11'(hc);
        vga_in.vcount = 11'(vc);
        vga_in.rgb = rgb;
    endtask

    task automatic hold_check(input string tag, input int hc, input int vc,
                              input logic [11:0] rgb, input logic [11:0] want);
        set_pix(1'b0, 1'b0, hc, vc, rgb);
        repeat (3) step();
        check_val(tag, 38'(vga_out.rgb), 38'(want));
    endtask

    task automatic write_card(input int addr, input int st, input int sym);
        wr_en = 1'b1;
        wr_addr = 4'(addr);
        wr_state = 2'(st);
        wr_symbol = 3'(sym);
    endtask

    task automatic vblank_pulse();
        vga_in.vblnk = 1'b1;
        step();
        wr_en = 1'b0;
        check_val("tick_pulse", 38'(frame_tick), 38'(1));
        step();
        check_val("tick_single", 38'(frame_tick), 38'(0));
        vga_in.vblnk = 1'b0;
        step();
    endtask

    initial begin
        m_reset();
        set_pix(1'b0, 1'b0, 500, 300, 12'habc);
        repeat (3) step();
        check_val("reset_out", out_bus(), 38'(0));
        rst_n = 1'b1;

        hold_check("default_card", 384, 272, 12'h123, 12'h35a);
        hold_check("gap_pixel", 440, 272, 12'h456, 12'h456);
        hold_check("left_of_grid", 383, 272, 12'h789, 12'h789);
        set_pix(1'b1, 1'b0, 384, 272, 12'h000);
        repeat (3) step();
        check_val("hblank_zero", 38'(vga_out.rgb), 38'(0));

        set_pix(1'b0, 1'b0, 458, 346, 12'h111);
        write_card(5, 1, 2);
        step();
        wr_en = 1'b0;
        hold_check("pending_hidden", 458, 346, 12'h111, 12'h35a);
        vblank_pulse();
        hold_check("revealed_sym2", 458, 346, 12'h111, 12'h00f);

        write_card(5, 2, 0);
        step();
        wr_en = 1'b0;
        vblank_pulse();
        hold_check("matched_card", 458, 346, 12'h2a2, 12'h2a2);

        write_card(6, 1, 0);
        vblank_pulse();
        hold_check("commit_edge_write", 522, 346, 12'h000, 12'h35a);
        vblank_pulse();
        hold_check("commit_edge_later", 522, 346, 12'h000, 12'hf00);

        write_card(7, 1, 3);
        step();
        write_card(7, 1, 4);
        step();
        wr_en = 1'b0;
        vblank_pulse();
        hold_check("last_write_wins", 586, 346, 12'h000, 12'hf0f);

        cursor_idx = 4'd0;
        cursor_en = 1'b1;
        for (int f = 0; f < 34; f++) begin
            vblank_pulse();
            set_pix(1'b0, 1'b0, 386, 300, 12'h000);
            repeat (3) step();
            set_pix(1'b0, 1'b0, 400, 300, 12'h000);
            repeat (3) step();
            check_val("no_border_inner", 38'(vga_out.rgb == 12'hfff), 38'(0));
        end

        // Mid-line reset clears the output immediately.
        set_pix(1'b0, 1'b0, 458, 346, 12'h777);
        step();
        rst_n = 1'b0;
        m_reset();
        #1;
        check_val("async_reset", out_bus(), 38'(0));
        check_val("async_reset_tick", 38'(frame_tick), 38'(0));
        repeat (2) step();
        rst_n = 1'b1;
        hold_check("after_reset", 458, 346, 12'h777, 12'h35a);

        for (int f = 0; f < 70; f++) begin
            cursor_idx = 4'($urandom_range(0, 15));
            cursor_en = 1'($urandom_range(0, 3) != 0);
            for (int c = 0; c < 200; c++) begin
                vga_in.hs = 1'($urandom_range(0, 1));
                vga_in.vs = 1'($urandom_range(0, 1));
                vga_in.vblnk = (c >= 180);
                vga_in.hblnk = ((c % 25) >= 22);
                vga_in.hcount = 11'($urandom_range(376, 650));
                vga_in.vcount = 11'($urandom_range(266, 535));
                vga_in.rgb = 12'($urandom_range(0, 4095));
                wr_en = ($urandom_range(0, 7) == 0);
                wr_addr = 4'($urandom_range(0, 15));
                wr_state = 2'($urandom_range(0, 3));
                wr_symbol = 3'($urandom_range(0, 7));
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
